// File: rtl/primus_alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one primus_alu writer port among NUM_REQ requesters.
// Latency: grant one edge after a request is seen in IDLE; completion pulse follows ALU ready; one transaction in flight.
// Backpressure: requesters hold valid/data until their req_ready_o pulse; stale ALU ready is drained before the next grant.
// Optional build macro PRIMUS_ALU_ARB_TIMEOUT_EN adds timeout_o and an ISSUE-state cycle limit (TIMEOUT_CYCLES).
module primus_alu_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [DATA_W-1:0]         alu_data_o,
  output logic                      alu_valid_o,
  input  logic                      alu_ready_i,
  output logic [IDX_W-1:0]          grant_idx_o,
  output logic                      busy_o
`ifdef PRIMUS_ALU_ARB_TIMEOUT_EN
  ,
  output logic                      timeout_o
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic             found;
  int               cand;

  // Reject configurations the arbiter cannot serve sensibly.
  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("primus_alu_arbiter: NUM_REQ must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("primus_alu_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef PRIMUS_ALU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;
`endif

  // Round-robin pick: first valid requester searching upward from ptr+1, wrapping; ptr itself is last.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    cand   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_valid_i[cand]) begin
        winner = IDX_W'(cand);
        found  = 1'b1;
      end
    end
  end

  // Completion pulse: only the granted requester sees ALU ready, and only while issuing.
  always_comb begin
    req_ready_o = '0;
    if (state == ISSUE) req_ready_o[grant_idx_o] = alu_ready_i;
  end

  assign busy_o = (state != IDLE);

  // Sequencer: grant in IDLE, hold the captured word in ISSUE, wait out stale ready in DRAIN.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      ptr         <= IDX_W'(NUM_REQ - 1);
      alu_valid_o <= 1'b0;
      alu_data_o  <= '0;
      grant_idx_o <= '0;
`ifdef PRIMUS_ALU_ARB_TIMEOUT_EN
      to_cnt      <= '0;
      timeout_o   <= 1'b0;
`endif
    end else begin
`ifdef PRIMUS_ALU_ARB_TIMEOUT_EN
      timeout_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            alu_data_o  <= req_data_i[int'(winner)*DATA_W +: DATA_W];
            alu_valid_o <= 1'b1;
            grant_idx_o <= winner;
            ptr         <= winner;
            state       <= ISSUE;
`ifdef PRIMUS_ALU_ARB_TIMEOUT_EN
            to_cnt      <= '0;
`endif
          end
        end
        ISSUE: begin
          if (alu_ready_i) begin
            alu_valid_o <= 1'b0;
            state       <= DRAIN;
          end
`ifdef PRIMUS_ALU_ARB_TIMEOUT_EN
          // Give up on a silent ALU; the request stays pending but ptr has already moved past it.
          else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            alu_valid_o <= 1'b0;
            timeout_o   <= 1'b1;
            state       <= DRAIN;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        DRAIN: begin
          if (!alu_ready_i) state <= IDLE;
        end
        default: begin
          alu_valid_o <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_primus_alu_arbiter.sv
// Directed bench for primus_alu_arbiter with a behavioural 3-cycle ALU.
// The ALU raises ready in the 3rd cycle after the grant edge and keeps it through two more cycles.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_primus_alu_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   alu_data;
  logic           alu_valid;
  logic           alu_ready;
  logic [IW-1:0]  grant_idx;
  logic           busy;
`ifdef PRIMUS_ALU_ARB_TIMEOUT_EN
  logic           timeout;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] sr;
  logic       alu_auto = 1'b1;
  logic       alu_man = 1'b0;
  logic       auto_drop = 1'b1;
  logic       prev_av = 1'b0;
  logic       rose = 1'b0;
  logic [N-1:0] last_rr = '0;

  primus_alu_arbiter #(
    .NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_data_i(req_data), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .alu_data_o(alu_data), .alu_valid_o(alu_valid), .alu_ready_i(alu_ready),
    .grant_idx_o(grant_idx), .busy_o(busy)
`ifdef PRIMUS_ALU_ARB_TIMEOUT_EN
    , .timeout_o(timeout)
`endif
  );

  always #5 clk = ~clk;

  // ALU model: valid history shift register, ready while the two oldest samples are both high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[1:0], alu_valid};
  end
  assign alu_ready = alu_auto ? (sr[1] & sr[2]) : alu_man;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One cycle: sample after the falling edge, note a new grant, let served requesters drop.
  task automatic step();
    prev_av = alu_valid;
    @(negedge clk);
    rose    = alu_valid && !prev_av;
    last_rr = req_ready;
    if (auto_drop) req_valid = req_valid & ~req_ready;
  endtask

  task automatic wait_grant(input int budget);
    int c = 0;
    do begin
      step();
      c++;
    end while (!rose && c < budget);
    check("grant_seen", 32'(rose), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy && c < budget) begin
      step();
      c++;
    end
    check("idle", 32'(busy), 32'd0);
  endtask

  task automatic set_data(input int k, input logic [W-1:0] d);
    req_data[k*W +: W] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g_idx[$];
    int g_cyc[$];
    logic [W-1:0] g_dat[$];
    int cyc;
    int vcount, pulses, pulse_c, other, first_idle;

    // Reset state
    #2;
    check("rst_valid", 32'(alu_valid), 32'd0);
    check("rst_data",  32'(alu_data),  32'd0);
    check("rst_grant", 32'(grant_idx), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_rr",    32'(req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // All four requesters held: order 0,1,2,3,0, 8 cycles apart
    for (int k = 0; k < N; k++) set_data(k, 16'h1000 + 16'(k));
    auto_drop = 1'b0;
    req_valid = 4'b1111;
    cyc = 0;
    for (int c = 0; c < 60 && g_idx.size() < 5; c++) begin
      step();
      cyc++;
      if (rose) begin
        g_idx.push_back(int'(grant_idx));
        g_cyc.push_back(cyc);
        g_dat.push_back(alu_data);
      end
    end
    check("rr_ngrants", 32'(g_idx.size()), 32'd5);
    if (g_idx.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check("rr_order", 32'(g_idx[i]), 32'(i % N));
        check("rr_data",  32'(g_dat[i]), 32'h1000 + 32'(i % N));
        if (i > 0) check("rr_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd8);
      end
    end
    req_valid = '0;
    auto_drop = 1'b1;
    wait_idle(20);

    // Single requester 1: latency profile of one transaction
    set_data(1, 16'hABCD);
    req_valid = 4'b0010;
    step();
    check("a_grant", 32'(grant_idx), 32'd1);
    check("a_data",  32'(alu_data),  32'hABCD);
    check("a_busy",  32'(busy),      32'd1);
    vcount = alu_valid ? 1 : 0;
    pulses = 0; pulse_c = -1; other = 0; first_idle = -1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (alu_valid) vcount++;
      if (last_rr[1]) begin pulses++; pulse_c = c; end
      if ((last_rr & 4'b1101) != 0) other++;
      if (!busy && first_idle < 0) first_idle = c;
    end
    check("a_valid_cycles", 32'(vcount),     32'd4);
    check("a_pulses",       32'(pulses),     32'd1);
    check("a_pulse_cycle",  32'(pulse_c),    32'd3);
    check("a_other_rr",     32'(other),      32'd0);
    check("a_idle_cycle",   32'(first_idle), 32'd7);

    // Requester 2 served, requester 0 arrives mid-ISSUE: wrap to 0, not back to 2
    auto_drop = 1'b0;
    set_data(2, 16'h2222);
    req_valid = 4'b0100;
    wait_grant(10);
    check("c_grant2", 32'(grant_idx), 32'd2);
    check("c_data2",  32'(alu_data),  32'h2222);
    step();
    set_data(0, 16'h0C0C);
    req_valid[0] = 1'b1;
    wait_grant(20);
    check("c_grant0", 32'(grant_idx), 32'd0);
    check("c_data0",  32'(alu_data),  32'h0C0C);
    req_valid = '0;
    auto_drop = 1'b1;
    wait_idle(20);

    // Requester drops valid during ISSUE: transaction still completes with a pulse
    set_data(1, 16'h5555);
    req_valid = 4'b0010;
    wait_grant(10);
    check("e_grant", 32'(grant_idx), 32'd1);
    req_valid = '0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (last_rr[1]) pulses++;
    end
    check("e_pulses", 32'(pulses), 32'd1);
    wait_idle(20);

    // Stale ready in DRAIN blocks a new grant until ready is sampled low
    auto_drop = 1'b0;
    alu_auto  = 1'b0;
    alu_man   = 1'b0;
    set_data(3, 16'h3333);
    req_valid = 4'b1000;
    wait_grant(10);
    check("d_grant", 32'(grant_idx), 32'd3);
    step();
    step();
    check("d_wait_valid", 32'(alu_valid), 32'd1);
    check("d_wait_rr",    32'(req_ready), 32'd0);
    alu_man = 1'b1;
    #1;
    check("d_pulse", 32'(req_ready), 32'b1000);
    for (int i = 0; i < 3; i++) begin
      step();
      check("d_drain_valid", 32'(alu_valid), 32'd0);
      check("d_drain_rr",    32'(req_ready), 32'd0);
      check("d_drain_busy",  32'(busy),      32'd1);
    end
    alu_man = 1'b0;
    step();
    check("d_exit_busy",  32'(busy),      32'd0);
    check("d_exit_valid", 32'(alu_valid), 32'd0);
    step();
    check("d_regrant_valid", 32'(alu_valid), 32'd1);
    check("d_regrant_idx",   32'(grant_idx), 32'd3);

    // Reset during ISSUE: outputs clear at once, pointer restarts so 0 beats 3
    rst_n = 1'b0;
    #1;
    check("r_valid", 32'(alu_valid), 32'd0);
    check("r_busy",  32'(busy),      32'd0);
    check("r_grant", 32'(grant_idx), 32'd0);
    check("r_data",  32'(alu_data),  32'd0);
    check("r_rr",    32'(req_ready), 32'd0);
    alu_auto = 1'b1;
    set_data(0, 16'h0A0A);
    req_valid = 4'b1001;
    step();
    rst_n = 1'b1;
    wait_grant(10);
    check("r_grant0", 32'(grant_idx), 32'd0);
    check("r_data0",  32'(alu_data),  32'h0A0A);
    req_valid = '0;
    auto_drop = 1'b1;
    wait_idle(20);

`ifdef PRIMUS_ALU_ARB_TIMEOUT_EN
    // Silent ALU: timeout 8 cycles after the grant, no pulse, next grant to the other requester
    auto_drop = 1'b0;
    alu_auto  = 1'b0;
    alu_man   = 1'b0;
    set_data(1, 16'h1111);
    req_valid = 4'b0011;
    wait_grant(10);
    check("t_grant1", 32'(grant_idx), 32'd1);
    pulses = 0; pulse_c = -1; other = 0;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (timeout) begin pulses++; if (pulse_c < 0) pulse_c = c; end
      if (last_rr != 0) other++;
    end
    check("t_pulses", 32'(pulses),  32'd1);
    check("t_cycle",  32'(pulse_c), 32'd8);
    check("t_rr",     32'(other),   32'd0);
    wait_grant(10);
    check("t_next_grant", 32'(grant_idx), 32'd0);
    req_valid = '0;
    wait_idle(40);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
